// File: rtl/ctl_missile_en_multi.sv
// Enemy missile controller: N independent slots, each launched at the enemy position,
// stepped down on a shared tick and retired at the screen bottom or on a hit.
module ctl_missile_en_multi #(
    parameter int N_SLOTS    = 4,
    parameter int POS_W      = 11,
    parameter int TICK_LIMIT = 90000,
    parameter int TICK_W     = 21,
    parameter int STEP       = 1,
    parameter int Y_MAX      = 768,
    parameter int COOLDOWN   = 0,
    parameter int CD_W       = 21
) (
    input  logic                       pclk,
    input  logic                       rst_n,
    input  logic [POS_W-1:0]           xpos_in,
    input  logic [POS_W-1:0]           ypos_in,
    input  logic                       fire,
    input  logic                       enemy_alive,
    input  logic                       pause,
    input  logic [N_SLOTS-1:0]         hit_clr,
    output logic [N_SLOTS-1:0]         on_out,
    output logic [N_SLOTS*POS_W-1:0]   xpos_out,
    output logic [N_SLOTS*POS_W-1:0]   ypos_out,
    output logic                       fire_ack,
    output logic                       full,
    output logic [N_SLOTS-1:0]         dbg_slot_state
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FLY  = 1'b1
    } slot_state_t;

    localparam logic [POS_W:0]    C_STEP  = (POS_W+1)'(STEP);
    localparam logic [POS_W:0]    C_Y_MAX = (POS_W+1)'(Y_MAX);
    localparam logic [TICK_W-1:0] C_TICK  = TICK_W'(TICK_LIMIT);
    localparam logic [CD_W-1:0]   C_CD    = CD_W'(COOLDOWN);

    slot_state_t          r_state     [N_SLOTS];
    slot_state_t          w_state_nxt [N_SLOTS];
    logic [POS_W-1:0]     r_x         [N_SLOTS];
    logic [POS_W-1:0]     r_y         [N_SLOTS];
    logic [POS_W-1:0]     w_x_nxt     [N_SLOTS];
    logic [POS_W-1:0]     w_y_nxt     [N_SLOTS];
    logic [POS_W:0]       w_sum       [N_SLOTS];

    logic [TICK_W-1:0]    r_tick_cnt;
    logic [CD_W-1:0]      r_cd;
    logic                 r_fire_ack;
    logic                 r_full;

    logic                 w_tick;
    logic                 w_accept;
    logic                 w_found;
    logic [N_SLOTS-1:0]   w_free;
    logic [N_SLOTS-1:0]   w_alloc;
    logic [N_SLOTS-1:0]   w_fly_nxt;

    assign w_tick   = !pause && (r_tick_cnt == C_TICK);
    assign w_accept = fire && enemy_alive && !pause && (r_cd == '0) && (|w_free);

    // Free mask comes from registered state, so a slot retired this cycle is
    // only allocatable from the next cycle on.
    always_comb begin
        w_free  = '0;
        w_alloc = '0;
        w_found = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            w_free[i] = (r_state[i] == S_IDLE);
            if (w_free[i] && !w_found) begin
                w_alloc[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

    always_comb begin
        w_fly_nxt = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_x_nxt[i]     = r_x[i];
            w_y_nxt[i]     = r_y[i];
            w_sum[i]       = {1'b0, r_y[i]} + C_STEP;
            if (r_state[i] == S_IDLE) begin
                if (w_accept && w_alloc[i]) begin
                    w_state_nxt[i] = S_FLY;
                    w_x_nxt[i]     = xpos_in;
                    w_y_nxt[i]     = ypos_in;
                end
            end else begin
                // A hit wins over a same-cycle tick; a bottom retire keeps the old y.
                if (hit_clr[i]) begin
                    w_state_nxt[i] = S_IDLE;
                end else if (w_tick) begin
                    if (w_sum[i] >= C_Y_MAX) begin
                        w_state_nxt[i] = S_IDLE;
                    end else begin
                        w_y_nxt[i] = w_sum[i][POS_W-1:0];
                    end
                end
            end
            w_fly_nxt[i] = (w_state_nxt[i] == S_FLY);
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                r_state[i] <= S_IDLE;
                r_x[i]     <= '0;
                r_y[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_x[i]     <= w_x_nxt[i];
                r_y[i]     <= w_y_nxt[i];
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_cd       <= '0;
            r_fire_ack <= 1'b0;
            r_full     <= 1'b0;
        end else begin
            if (!pause) begin
                r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
            end
            if (w_accept) begin
                r_cd <= C_CD;
            end else if ((r_cd != '0) && !pause) begin
                r_cd <= r_cd - CD_W'(1);
            end
            r_fire_ack <= w_accept;
            r_full     <= &w_fly_nxt;
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_SLOTS; g++) begin : g_out
            assign on_out[g]                   = (r_state[g] == S_FLY);
            assign dbg_slot_state[g]           = r_state[g];
            assign xpos_out[g*POS_W +: POS_W]  = r_x[g];
            assign ypos_out[g*POS_W +: POS_W]  = r_y[g];
        end
    endgenerate

    assign fire_ack = r_fire_ack;
    assign full     = r_full;

endmodule

// File: tb/tb_ctl_missile_en_multi.sv
// Directed bench for ctl_missile_en_multi: launch/retire, cooldown, hit vs tick,
// gating and pause phase, plus a STEP=3 narrow-bus instance for the bottom retire.
module tb_ctl_missile_en_multi;

    localparam int N  = 4;
    localparam int PW = 11;
    localparam int EW = 3 + PW + PW;

    logic              pclk = 1'b0;
    logic              rst_n = 1'b0;
    logic [PW-1:0]     xpos_in, ypos_in;
    logic              fire, enemy_alive, pause;
    logic [N-1:0]      hit_clr;
    logic [N-1:0]      on_out, dbg_state;
    logic [N*PW-1:0]   xpos_out, ypos_out;
    logic              fire_ack, full;

    logic [4:0]        x3, y3;
    logic              fire3;
    logic [N-1:0]      on3, dbg3;
    logic [N*5-1:0]    xo3, yo3;
    logic              ack3, full3;

    logic [EW-1:0]     exp_q[$];
    int                n_checks = 0;
    int                n_errors = 0;

    always #5 pclk = ~pclk;

    ctl_missile_en_multi #(
        .N_SLOTS(4), .POS_W(PW), .TICK_LIMIT(3), .TICK_W(21), .STEP(1),
        .Y_MAX(20), .COOLDOWN(2), .CD_W(21)
    ) u_dut (
        .pclk(pclk), .rst_n(rst_n), .xpos_in(xpos_in), .ypos_in(ypos_in),
        .fire(fire), .enemy_alive(enemy_alive), .pause(pause), .hit_clr(hit_clr),
        .on_out(on_out), .xpos_out(xpos_out), .ypos_out(ypos_out),
        .fire_ack(fire_ack), .full(full), .dbg_slot_state(dbg_state)
    );

    ctl_missile_en_multi #(
        .N_SLOTS(4), .POS_W(5), .TICK_LIMIT(3), .TICK_W(21), .STEP(3),
        .Y_MAX(20), .COOLDOWN(2), .CD_W(21)
    ) u_dut3 (
        .pclk(pclk), .rst_n(rst_n), .xpos_in(x3), .ypos_in(y3),
        .fire(fire3), .enemy_alive(enemy_alive), .pause(pause), .hit_clr(4'b0000),
        .on_out(on3), .xpos_out(xo3), .ypos_out(yo3),
        .fire_ack(ack3), .full(full3), .dbg_slot_state(dbg3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] y_of(input int s);
        return ypos_out[s*PW +: PW];
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge pclk);
    endtask

    task automatic expect_launch(input int s, input int x, input int y);
        exp_q.push_back({3'(s), PW'(x), PW'(y)});
    endtask

    task automatic wait_y_change(input int s, input int bound, output int cyc);
        logic [PW-1:0] prev;
        prev = y_of(s);
        cyc  = 0;
        while (cyc < bound) begin
            step(1);
            cyc++;
            if (y_of(s) != prev) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL wait_y_change slot %0d: no change after %0d cycles", s, bound);
    endtask

    task automatic wait_off(input string name, input int bound, input bit use3);
        for (int k = 0; k < bound; k++) begin
            step(1);
            if (use3 ? !on3[0] : !on_out[0]) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL %s: slot 0 still on after %0d cycles", name, bound);
    endtask

    // Scoreboard monitor: every acknowledged launch is matched against the queue.
    always @(negedge pclk) begin : mon
        logic [EW-1:0] e;
        int s;
        if (rst_n === 1'b1 && fire_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ack: got ack with on_out=%b, expected none", on_out);
            end else begin
                e = exp_q.pop_front();
                s = int'(e[EW-1 -: 3]);
                chk("ack_on", 32'(on_out[s]), 32'd1);
                chk("ack_x", 32'(xpos_out[s*PW +: PW]), 32'(e[2*PW-1 -: PW]));
                chk("ack_y", 32'(ypos_out[s*PW +: PW]), 32'(e[PW-1:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        logic [PW-1:0] y0_old, y1_old, y_rec;
        fire = 0; enemy_alive = 1; pause = 0; hit_clr = '0;
        xpos_in = '0; ypos_in = '0; fire3 = 0; x3 = '0; y3 = '0;

        // reset state
        step(3);
        chk("rst_on", 32'(on_out), 32'd0);
        chk("rst_x", 32'(|xpos_out), 32'd0);
        chk("rst_y", 32'(|ypos_out), 32'd0);
        chk("rst_ack", 32'(fire_ack), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        rst_n = 1'b1;
        step(2);

        // 1: reset mid-flight
        xpos_in = 50; ypos_in = 2; fire = 1; expect_launch(0, 50, 2);
        step(1); fire = 0;
        step(2);
        xpos_in = 60; ypos_in = 3; fire = 1; expect_launch(1, 60, 3);
        step(1); fire = 0;
        step(2);
        chk("t1_two_on", 32'(on_out), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_on", 32'(on_out), 32'd0);
        chk("t1_async_x", 32'(|xpos_out), 32'd0);
        chk("t1_async_y", 32'(|ypos_out), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(3);
        chk("t1_no_resume", 32'(on_out), 32'd0);

        // 2: single launch, step, bottom retire
        xpos_in = 100; ypos_in = 10; fire = 1; expect_launch(0, 100, 10);
        step(1); fire = 0;
        chk("t2_ack", 32'(fire_ack), 32'd1);
        chk("t2_on", 32'(on_out), 32'd1);
        wait_y_change(0, 5, c);
        chk("t2_y11", 32'(y_of(0)), 32'd11);
        chk("t2_ack_pulse", 32'(fire_ack), 32'd0);
        wait_off("t2_retire", 60, 1'b0);
        chk("t2_y_hold", 32'(y_of(0)), 32'd19);

        // 3: held fire with cooldown fills slots 0..3
        step(2);
        for (int k = 0; k < 12; k++) begin
            xpos_in = PW'(200 + k); ypos_in = PW'(k); fire = 1;
            if (k % 3 == 0) expect_launch(k / 3, 200 + k, k);
            step(1);
        end
        chk("t3_all_on", 32'(on_out), 32'hF);
        chk("t3_full", 32'(full), 32'd1);
        step(4);
        chk("t3_full_hold", 32'(on_out), 32'hF);

        // 4: hit on a tick cycle, refire allocates slot 1 only afterwards
        fire = 0;
        wait_y_change(0, 6, c);
        step(3);
        y0_old = y_of(0); y1_old = y_of(1);
        hit_clr = 4'b0010; fire = 1; xpos_in = 300; ypos_in = 7;
        step(1);
        hit_clr = '0;
        chk("t4_on", 32'(on_out), 32'hD);
        chk("t4_y1_hold", 32'(y_of(1)), 32'(y1_old));
        chk("t4_tick_seen", 32'(y_of(0)), 32'(y0_old) + 1);
        chk("t4_no_ack", 32'(fire_ack), 32'd0);
        chk("t4_not_full", 32'(full), 32'd0);
        xpos_in = 301; ypos_in = 8; expect_launch(1, 301, 8);
        step(1); fire = 0;
        chk("t4_refill", 32'(on_out), 32'hF);

        // 5: gating and pause
        hit_clr = 4'hF; step(1); hit_clr = '0;
        chk("t5_cleared", 32'(on_out), 32'd0);
        enemy_alive = 0; fire = 1; step(3);
        chk("t5_dead", 32'(on_out), 32'd0);
        enemy_alive = 1; pause = 1; step(3);
        chk("t5_pause_fire", 32'(on_out), 32'd0);
        pause = 0; fire = 0; step(1);
        xpos_in = 40; ypos_in = 5; fire = 1; expect_launch(0, 40, 5);
        step(1); fire = 0;
        wait_y_change(0, 6, c);
        y_rec = y_of(0);
        step(1);
        pause = 1; fire = 1;
        step(10);
        chk("t5_y_frozen", 32'(y_of(0)), 32'(y_rec));
        chk("t5_one_on", 32'(on_out), 32'd1);
        pause = 0; fire = 0;
        wait_y_change(0, 8, c);
        chk("t5_phase", 32'(c), 32'd3);
        chk("t5_y_after", 32'(y_of(0)), 32'(y_rec) + 1);
        pause = 1; hit_clr = 4'b0001; step(1);
        pause = 0; hit_clr = '0;
        chk("t5_hit_in_pause", 32'(on_out), 32'd0);

        // 6: STEP=3 bottom retire, no wrap on a 5-bit bus
        x3 = 7; y3 = 18; fire3 = 1; step(1); fire3 = 0;
        chk("t6_ack", 32'(ack3), 32'd1);
        chk("t6_on", 32'(on3), 32'd1);
        chk("t6_y", 32'(yo3[4:0]), 32'd18);
        wait_off("t6_retire18", 8, 1'b1);
        chk("t6_y_hold18", 32'(yo3[4:0]), 32'd18);
        step(3);
        x3 = 9; y3 = 30; fire3 = 1; step(1); fire3 = 0;
        chk("t6_on30", 32'(on3), 32'd1);
        chk("t6_x9", 32'(xo3[4:0]), 32'd9);
        wait_off("t6_retire30", 8, 1'b1);
        chk("t6_y_hold30", 32'(yo3[4:0]), 32'd30);

        step(2);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
